// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the data-port memory responder.
// Holds the FSM state encoding, the bus geometry and the access fault rule.
package mem_rsp_pkg;

    localparam int XLEN        = 64;
    localparam int DWORD_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    // Fault when the access is not doubleword aligned, or when any address bit
    // above the storage index is set. Aligned addresses below DEPTH_BYTES always
    // fit their 8 bytes, because DEPTH_BYTES is a multiple of 8.
    function automatic logic f_addr_fault(input logic [XLEN-1:0] addr,
                                          input int unsigned     aw);
        logic [XLEN-1:0] upper;
        upper = addr >> aw;
        return (addr[2:0] != 3'd0) || (upper != '0);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bundle between the core's data port and the memory responder.
// The master side is the processor; the slave side is data_mem_responder.
interface mem_rsp_if;
    import mem_rsp_pkg::*;

    logic            req_valid;
    logic            req_ready;
    logic            req_write;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_wdata;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [XLEN-1:0] rsp_rdata;
    logic            rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_byte_array.sv
// Little-endian byte storage: per-lane synchronous write, combinational 8-byte read.
// Contents are deliberately not reset so that they survive a responder reset.
module mem_byte_array
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int AW          = $clog2(DEPTH_BYTES)
) (
    input  logic                   clk,
    input  logic [DWORD_BYTES-1:0] i_lane_we,
    input  logic [AW-1:0]          i_addr,
    input  logic [XLEN-1:0]        i_wdata,
    output logic [XLEN-1:0]        o_rdata
);

    logic [7:0] r_mem [DEPTH_BYTES];

    always_ff @(posedge clk) begin
        for (int k = 0; k < DWORD_BYTES; k++) begin
            if (i_lane_we[k]) begin
                r_mem[i_addr + AW'(k)] <= i_wdata[8*k +: 8];
            end
        end
    end

    for (genvar g = 0; g < DWORD_BYTES; g++) begin : g_rd_lane
        assign o_rdata[8*g +: 8] = r_mem[i_addr + AW'(g)];
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port memory responder: one outstanding load/store, response after
// WAIT_CYCLES extra cycles, held until the requester takes it.
module data_mem_responder
    import mem_rsp_pkg::*;
#(
    parameter int DEPTH_BYTES = 256,
    parameter int WAIT_CYCLES = 2
) (
    input logic     clk,
    input logic     reset,
    mem_rsp_if.slave bus
);

    localparam int         AW        = $clog2(DEPTH_BYTES);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam logic [1:0] S_IDLE    = IDLE;
    localparam logic [1:0] S_BUSY    = BUSY;
    localparam logic [1:0] S_RESP    = RESP;

    logic [1:0]             r_state;
    logic [3:0]             r_cnt;
    logic                   r_write;
    logic [XLEN-1:0]        r_addr;
    logic [XLEN-1:0]        r_wdata;
    logic [XLEN-1:0]        r_rdata;
    logic                   r_err;

    logic                   w_accept;
    logic                   w_do_access;
    logic                   w_acc_write;
    logic                   w_fault;
    logic [XLEN-1:0]        w_acc_addr;
    logic [XLEN-1:0]        w_acc_wdata;
    logic [XLEN-1:0]        w_mem_rdata;
    logic [DWORD_BYTES-1:0] w_lane_we;

    // Accept is gated by reset so nothing is taken (or written) while reset is held.
    assign w_accept = bus.req_valid && (r_state == S_IDLE) && reset;

    // Zero-wait builds perform the access on the accept edge straight from the bus.
    always_comb begin
        w_acc_write = r_write;
        w_acc_addr  = r_addr;
        w_acc_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_acc_write = bus.req_write;
            w_acc_addr  = bus.req_addr;
            w_acc_wdata = bus.req_wdata;
        end
    end

    assign w_do_access = (WAIT_CYCLES == 0) ? w_accept
                       : ((r_state == S_BUSY) && (r_cnt == 4'd1) && reset);
    assign w_fault     = f_addr_fault(w_acc_addr, AW);
    assign w_lane_we   = {DWORD_BYTES{w_do_access && w_acc_write && !w_fault}};

    mem_byte_array #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_mem (
        .clk       (clk),
        .i_lane_we (w_lane_we),
        .i_addr    (w_acc_addr[AW-1:0]),
        .i_wdata   (w_acc_wdata),
        .o_rdata   (w_mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_write <= bus.req_write;
            r_addr  <= bus.req_addr;
            r_wdata <= bus.req_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_do_access) begin
                r_rdata <= (w_acc_write || w_fault) ? '0 : w_mem_rdata;
                r_err   <= w_fault;
            end else if ((r_state == S_RESP) && bus.rsp_ready) begin
                r_rdata <= '0;
                r_err   <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_cnt   <= WAIT_INIT;
                        r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == S_IDLE);
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rdata;
    assign bus.rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance for the main
// sequences and a WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_data_mem_responder;
    import mem_rsp_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_rsp_if if_a ();
    mem_rsp_if if_b ();

    data_mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a.slave)
    );

    data_mem_responder #(.DEPTH_BYTES(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b.slave)
    );

    localparam logic [63:0] D0   = 64'h1122334455667788;
    localparam logic [63:0] DA5  = 64'hA5A5A5A5A5A5A5A5;
    localparam logic [63:0] DF8  = 64'h0102030405060708;
    localparam logic [63:0] DOLD = 64'hCAFEF00D00000001;
    localparam logic [63:0] DNEW = 64'h0BADBEEF00000002;
    localparam logic [63:0] D1   = 64'h0F0E0D0C0B0A0908;
    localparam logic [63:0] D2   = 64'h8877665544332211;

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a request on DUT A, wait for accept, then count edges until rsp_valid.
    task automatic issue(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                         output int lat);
        int guard;
        if_a.req_valid = 1'b1;
        if_a.req_write = wr;
        if_a.req_addr  = addr;
        if_a.req_wdata = wdata;
        guard = 0;
        while (!if_a.req_ready && guard < 20) begin
            tick();
            guard++;
        end
        tick();
        if_a.req_valid = 1'b0;
        lat = 1;
        while (!if_a.rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic collect(output logic [63:0] rd, output logic er);
        rd = if_a.rsp_rdata;
        er = if_a.rsp_err;
        if_a.rsp_ready = 1'b1;
        tick();
        if_a.rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                       output logic [63:0] rd, output logic er, output int lat);
        issue(wr, addr, wdata, lat);
        collect(rd, er);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] rd;
        logic        er;
        int          lat;
        logic        wr6  [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [63:0] ad6  [5] = '{64'h40, 64'h48, 64'h40, 64'h48, 64'h44};
        logic [63:0] wd6  [5] = '{D1, D2, 64'h0, 64'h0, 64'h0};
        logic [63:0] rd6  [5] = '{64'h0, 64'h0, D1, D2, 64'h0};
        logic        er6  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        if_a.req_valid = 1'b0; if_a.req_write = 1'b0; if_a.req_addr = '0;
        if_a.req_wdata = '0;   if_a.rsp_ready = 1'b0;
        if_b.req_valid = 1'b0; if_b.req_write = 1'b0; if_b.req_addr = '0;
        if_b.req_wdata = '0;   if_b.rsp_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(if_a.req_ready), 64'd1);
        check("rst_rsp_valid", 64'(if_a.rsp_valid), 64'd0);
        check("rst_rsp_rdata", if_a.rsp_rdata, 64'd0);
        check("rst_rsp_err",   64'(if_a.rsp_err), 64'd0);
        check("rst_b_ready",   64'(if_b.req_ready), 64'd1);
        reset = 1'b1;
        tick();

        // Store then load, with latency 1+WAIT_CYCLES
        txn(1'b1, 64'h10, D0, rd, er, lat);
        check("st10_lat",   64'(lat), 64'd3);
        check("st10_err",   64'(er), 64'd0);
        check("st10_rdata", rd, 64'd0);
        txn(1'b0, 64'h10, 64'h0, rd, er, lat);
        check("ld10_lat",   64'(lat), 64'd3);
        check("ld10_rdata", rd, D0);
        check("ld10_err",   64'(er), 64'd0);

        // Misaligned accesses
        txn(1'b1, 64'h08, DA5, rd, er, lat);
        txn(1'b0, 64'h13, 64'h0, rd, er, lat);
        check("ld13_err",   64'(er), 64'd1);
        check("ld13_rdata", rd, 64'd0);
        txn(1'b1, 64'h0B, 64'hFFFFFFFFFFFFFFFF, rd, er, lat);
        check("st0b_err",   64'(er), 64'd1);
        txn(1'b0, 64'h08, 64'h0, rd, er, lat);
        check("ld08_keep",  rd, DA5);

        // Out-of-range accesses
        txn(1'b1, 64'hF8, DF8, rd, er, lat);
        check("stf8_err",   64'(er), 64'd0);
        txn(1'b1, 64'h100, 64'hDEADDEADDEADDEAD, rd, er, lat);
        check("st100_err",  64'(er), 64'd1);
        txn(1'b0, 64'hF8, 64'h0, rd, er, lat);
        check("ldf8_keep",  rd, DF8);
        check("ldf8_err",   64'(er), 64'd0);
        txn(1'b0, 64'h8000000000000010, 64'h0, rd, er, lat);
        check("ldhi_err",   64'(er), 64'd1);
        check("ldhi_rdata", rd, 64'd0);

        // Response held under backpressure; extra request ignored
        issue(1'b0, 64'h10, 64'h0, lat);
        check("bp_lat", 64'(lat), 64'd3);
        if_a.req_valid = 1'b1;
        if_a.req_write = 1'b1;
        if_a.req_addr  = 64'h10;
        if_a.req_wdata = 64'hDEADBEEFDEADBEEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid", 64'(if_a.rsp_valid), 64'd1);
            check("bp_rdata", if_a.rsp_rdata, D0);
            check("bp_ready", 64'(if_a.req_ready), 64'd0);
        end
        if_a.req_valid = 1'b0;
        collect(rd, er);
        check("bp_collect", rd, D0);
        txn(1'b0, 64'h10, 64'h0, rd, er, lat);
        check("bp_no_store", rd, D0);

        // Reset while the store is still in BUSY drops it
        txn(1'b1, 64'h20, DOLD, rd, er, lat);
        if_a.req_valid = 1'b1;
        if_a.req_write = 1'b1;
        if_a.req_addr  = 64'h20;
        if_a.req_wdata = DNEW;
        tick();
        if_a.req_valid = 1'b0;
        check("busy_ready", 64'(if_a.req_ready), 64'd0);
        #2 reset = 1'b0;
        #1;
        check("rbusy_ready", 64'(if_a.req_ready), 64'd1);
        check("rbusy_valid", 64'(if_a.rsp_valid), 64'd0);
        tick();
        reset = 1'b1;
        txn(1'b0, 64'h20, 64'h0, rd, er, lat);
        check("rbusy_old", rd, DOLD);

        // Reset in RESP keeps the already-performed store
        issue(1'b1, 64'h20, DNEW, lat);
        reset = 1'b0;
        #1;
        check("rresp_valid", 64'(if_a.rsp_valid), 64'd0);
        check("rresp_ready", 64'(if_a.req_ready), 64'd1);
        tick();
        reset = 1'b1;
        txn(1'b0, 64'h20, 64'h0, rd, er, lat);
        check("rresp_new", rd, DNEW);

        // Reset clears held load data immediately
        issue(1'b0, 64'h10, 64'h0, lat);
        check("rload_pre", if_a.rsp_rdata, D0);
        reset = 1'b0;
        #1;
        check("rload_rdata", if_a.rsp_rdata, 64'd0);
        check("rload_err",   64'(if_a.rsp_err), 64'd0);
        tick();
        reset = 1'b1;
        tick();

        // Zero-wait instance: response the cycle after accept, one bubble per transaction
        if_b.rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_b.req_valid = 1'b1;
            if_b.req_write = wr6[i];
            if_b.req_addr  = ad6[i];
            if_b.req_wdata = wd6[i];
            check("b_idle_ready", 64'(if_b.req_ready), 64'd1);
            tick();
            check("b_rsp_valid", 64'(if_b.rsp_valid), 64'd1);
            check("b_busy_ready", 64'(if_b.req_ready), 64'd0);
            check("b_rdata", if_b.rsp_rdata, rd6[i]);
            check("b_err", 64'(if_b.rsp_err), 64'(er6[i]));
            tick();
            check("b_handoff", 64'(if_b.rsp_valid), 64'd0);
        end
        if_b.req_valid = 1'b0;
        if_b.rsp_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
